// File: rtl/ppu_pal_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ppu_pal_arbiter : palette RAM port arbiter (pixel lookups vs. CPU $2007)
// Revision 1.0
// ----------------------------------------------------------------------------
module ppu_pal_arbiter #(
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       render_en,
  input  logic       pix_valid,
  input  logic [4:0] pix_idx,
  input  logic [4:0] bd_idx,
  input  logic       grayscale,
  output logic       color_valid,
  output logic [5:0] color,
  output logic       pix_drop,
  input  logic       cpu_req,
  input  logic       cpu_we,
  input  logic [4:0] cpu_addr,
  input  logic [7:0] cpu_wdata,
  output logic       cpu_ack,
  output logic [7:0] cpu_rdata,
  output logic [4:0] pal_addr,
  output logic       pal_wr,
  output logic [7:0] pal_wdata,
  input  logic [7:0] pal_rdata
);

  localparam logic [7:0] STARVE_LIM8 = 8'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_CAP = 2'd1,
    ACK    = 2'd2
  } state_t;

  state_t     state;
  logic [7:0] wait_cnt;
  logic [4:0] eff_idx;
  logic       cpu_grant;
  logic       s1_valid;
  logic       s1_gray;
  logic       s1_drop;

  assign eff_idx = render_en ? pix_idx : bd_idx;

  // The CPU only steals a pixel slot once it has been refused long enough.
  assign cpu_grant = (state == IDLE) && cpu_req &&
                     (!pix_valid || (wait_cnt >= STARVE_LIM8));

  assign pal_addr  = cpu_grant ? cpu_addr : eff_idx;
  assign pal_wr    = cpu_grant & cpu_we;
  assign pal_wdata = cpu_wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      wait_cnt  <= 8'd0;
      cpu_ack   <= 1'b0;
      cpu_rdata <= 8'd0;
    end else begin
      cpu_ack <= 1'b0;

      if (!cpu_req || cpu_grant) begin
        wait_cnt <= 8'd0;
      end else if ((state == IDLE) && (wait_cnt != 8'hFF)) begin
        wait_cnt <= wait_cnt + 8'd1;
      end

      case (state)
        IDLE: begin
          if (cpu_grant) begin
            if (cpu_we) begin
              state   <= ACK;
              cpu_ack <= 1'b1;
            end else begin
              state <= RD_CAP;
            end
          end
        end
        RD_CAP: begin
          cpu_rdata <= pal_rdata;
          cpu_ack   <= 1'b1;
          state     <= ACK;
        end
        ACK: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Stage 2 lines up with pal_rdata, which answers the stage-1 address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      s1_gray     <= 1'b0;
      s1_drop     <= 1'b0;
      color_valid <= 1'b0;
      pix_drop    <= 1'b0;
      color       <= 6'd0;
    end else begin
      s1_valid    <= pix_valid;
      s1_gray     <= grayscale;
      s1_drop     <= pix_valid & cpu_grant;
      color_valid <= s1_valid;
      pix_drop    <= s1_valid & s1_drop;
      if (s1_valid && !s1_drop) begin
        color <= pal_rdata[5:0] & (s1_gray ? 6'h30 : 6'h3F);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ppu_pal_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_ppu_pal_arbiter : scoreboard bench with a mirrored 1-cycle palette RAM
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_ppu_pal_arbiter;

  localparam int STARVE = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       render_en = 1'b0;
  logic       pix_valid = 1'b0;
  logic [4:0] pix_idx = 5'd0;
  logic [4:0] bd_idx = 5'd0;
  logic       grayscale = 1'b0;
  logic       color_valid;
  logic [5:0] color;
  logic       pix_drop;
  logic       cpu_req = 1'b0;
  logic       cpu_we = 1'b0;
  logic [4:0] cpu_addr = 5'd0;
  logic [7:0] cpu_wdata = 8'd0;
  logic       cpu_ack;
  logic [7:0] cpu_rdata;
  logic [4:0] pal_addr;
  logic       pal_wr;
  logic [7:0] pal_wdata;
  logic [7:0] pal_rdata = 8'd0;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic       ram_fill = 1'b0;
  logic [7:0] mem[32];
  logic [7:0] shadow[32];
  logic [5:0] last_color = 6'd0;

  typedef struct { int cyc; logic [5:0] color; logic drop; } pix_exp_t;
  typedef struct { int cyc; logic rd; logic [7:0] data; } ack_exp_t;
  pix_exp_t pix_q[$];
  ack_exp_t ack_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ppu_pal_arbiter #(.STARVE_LIMIT(STARVE)) dut (
    .clk(clk), .rst(rst), .render_en(render_en), .pix_valid(pix_valid),
    .pix_idx(pix_idx), .bd_idx(bd_idx), .grayscale(grayscale),
    .color_valid(color_valid), .color(color), .pix_drop(pix_drop),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .pal_addr(pal_addr), .pal_wr(pal_wr), .pal_wdata(pal_wdata),
    .pal_rdata(pal_rdata)
  );

  function automatic logic [4:0] mirror(input logic [4:0] a);
    return (a[4] && (a[1:0] == 2'b00)) ? {1'b0, a[3:0]} : a;
  endfunction

  // Palette RAM: registered read, mirrored backdrop slots.
  always @(posedge clk) begin
    if (ram_fill) begin
      for (int i = 0; i < 32; i++) mem[i] <= 8'h80 + 8'(i);
    end else begin
      if (pal_wr) mem[mirror(pal_addr)] <= pal_wdata;
      pal_rdata <= mem[mirror(pal_addr)];
    end
  end

  function automatic logic [5:0] exp_color(input logic [4:0] a, input logic g);
    logic [7:0] v;
    v = shadow[mirror(a)];
    return v[5:0] & (g ? 6'h30 : 6'h3F);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_pix(input logic [4:0] a, input logic g, input logic dropped);
    pix_exp_t e;
    e.cyc  = cyc + 2;
    e.drop = dropped;
    if (dropped) begin
      e.color = last_color;
    end else begin
      e.color    = exp_color(a, g);
      last_color = e.color;
    end
    pix_q.push_back(e);
  endtask

  task automatic push_ack(input logic rd, input int lat, input logic [7:0] d);
    ack_exp_t e;
    e.cyc  = cyc + lat;
    e.rd   = rd;
    e.data = d;
    ack_q.push_back(e);
  endtask

  // Output monitor: pops the scoreboard whenever the DUT produces a result.
  always @(posedge clk) begin
    pix_exp_t pe;
    ack_exp_t ae;
    #2;
    if (!rst) begin
      if (color_valid) begin
        vectors++;
        if (pix_q.size() == 0) begin
          miscompares++;
          $display("FAIL color_unexpected: cycle %0d color %h drop %b, none expected", cyc, color, pix_drop);
        end else begin
          pe = pix_q.pop_front();
          if (pe.cyc != cyc || color !== pe.color || pix_drop !== pe.drop) begin
            miscompares++;
            $display("FAIL color: got cycle %0d color %h drop %b, expected cycle %0d color %h drop %b",
                     cyc, color, pix_drop, pe.cyc, pe.color, pe.drop);
          end
        end
      end else begin
        if (pix_drop !== 1'b0) begin
          vectors++;
          miscompares++;
          $display("FAIL pix_drop_without_valid: cycle %0d pix_drop %b expected 0", cyc, pix_drop);
        end
        if (pix_q.size() != 0 && pix_q[0].cyc <= cyc) begin
          vectors++;
          miscompares++;
          pe = pix_q.pop_front();
          $display("FAIL color_missing: cycle %0d color_valid 0, expected colour %h", cyc, pe.color);
        end
      end

      if (cpu_ack) begin
        vectors++;
        if (ack_q.size() == 0) begin
          miscompares++;
          $display("FAIL ack_unexpected: cycle %0d cpu_ack 1, none expected", cyc);
        end else begin
          ae = ack_q.pop_front();
          if (ae.cyc != cyc || (ae.rd && cpu_rdata !== ae.data)) begin
            miscompares++;
            $display("FAIL ack: got cycle %0d rdata %h, expected cycle %0d rdata %h (read %b)",
                     cyc, cpu_rdata, ae.cyc, ae.data, ae.rd);
          end
        end
      end else if (ack_q.size() != 0 && ack_q[0].cyc <= cyc) begin
        vectors++;
        miscompares++;
        ae = ack_q.pop_front();
        $display("FAIL ack_missing: cycle %0d cpu_ack 0, expected ack at %0d", cyc, ae.cyc);
      end
    end
  end

  task automatic test_reset();
    rst      = 1'b1;
    ram_fill = 1'b1;
    for (int i = 0; i < 32; i++) shadow[i] = 8'h80 + 8'(i);
    step();
    step();
    ram_fill = 1'b0;
    vectors++;
    if ({color_valid, color, pix_drop, cpu_ack, cpu_rdata} !== 17'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got valid %b color %h drop %b ack %b rdata %h, expected all 0",
               color_valid, color, pix_drop, cpu_ack, cpu_rdata);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_write_read();
    step();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 5'h03; cpu_wdata = 8'h2A;
    #1;
    vectors++;
    if (pal_wr !== 1'b1 || pal_addr !== 5'h03 || pal_wdata !== 8'h2A) begin
      miscompares++;
      $display("FAIL write_grant: got wr %b addr %h data %h, expected 1 03 2a", pal_wr, pal_addr, pal_wdata);
    end
    push_ack(1'b0, 1, 8'h00);
    shadow[3] = 8'h2A;
    step();
    cpu_req = 1'b0; cpu_we = 1'b0;
    step();
    step();
    cpu_req = 1'b1; cpu_addr = 5'h03;
    #1;
    vectors++;
    if (pal_wr !== 1'b0 || pal_addr !== 5'h03) begin
      miscompares++;
      $display("FAIL read_grant: got wr %b addr %h, expected 0 03", pal_wr, pal_addr);
    end
    push_ack(1'b1, 2, 8'h2A);
    step();
    step();
    cpu_req = 1'b0;
    step();
  endtask

  task automatic test_pixel();
    render_en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step();
      pix_valid = 1'b1; pix_idx = 5'h03; grayscale = (i >= 6);
      #1;
      vectors++;
      if (pal_addr !== 5'h03 || pal_wr !== 1'b0) begin
        miscompares++;
        $display("FAIL pixel_addr: got addr %h wr %b, expected 03 0", pal_addr, pal_wr);
      end
      push_pix(5'h03, grayscale, 1'b0);
    end
    step();
    pix_valid = 1'b0; grayscale = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_backdrop();
    logic [4:0] exp_a;
    step();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 5'h00; cpu_wdata = 8'h0F;
    push_ack(1'b0, 1, 8'h00);
    shadow[0] = 8'h0F;
    step();
    cpu_req = 1'b0; cpu_we = 1'b0;
    step();
    render_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      exp_a = (i < 2) ? 5'h00 : 5'h10;
      pix_valid = 1'b1; pix_idx = 5'h07; bd_idx = exp_a;
      #1;
      vectors++;
      if (pal_addr !== exp_a) begin
        miscompares++;
        $display("FAIL backdrop_addr: got %h expected %h", pal_addr, exp_a);
      end
      push_pix(exp_a, 1'b0, 1'b0);
    end
    step();
    pix_valid = 1'b0; render_en = 1'b1; bd_idx = 5'h00;
    repeat (3) step();
  endtask

  task automatic test_starve();
    logic [4:0] exp_a;
    for (int j = 0; j < 2; j++) begin
      step();
      pix_valid = 1'b1; pix_idx = 5'h08 + 5'(j);
      push_pix(pix_idx, 1'b0, 1'b0);
    end
    for (int i = 0; i < STARVE + 4; i++) begin
      step();
      pix_valid = 1'b1; pix_idx = 5'h0A + 5'(i);
      if (i == 0) begin
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'h05;
      end
      if (i == STARVE + 2) cpu_req = 1'b0;
      #1;
      exp_a = (i == STARVE) ? 5'h05 : pix_idx;
      vectors++;
      if (pal_addr !== exp_a || pal_wr !== 1'b0) begin
        miscompares++;
        $display("FAIL starve_addr[%0d]: got addr %h wr %b, expected %h 0", i, pal_addr, pal_wr, exp_a);
      end
      if (i == STARVE) push_ack(1'b1, 2, shadow[5]);
      push_pix(pix_idx, 1'b0, i == STARVE);
    end
    step();
    pix_valid = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_same_cycle();
    step();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 5'h01; cpu_wdata = 8'h05;
    push_ack(1'b0, 1, 8'h00);
    shadow[1] = 8'h05;
    step();
    cpu_req = 1'b0; cpu_we = 1'b0;
    step();
    step();
    pix_valid = 1'b1; pix_idx = 5'h01;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 5'h01; cpu_wdata = 8'h11;
    #1;
    vectors++;
    if (pal_wr !== 1'b0 || pal_addr !== 5'h01) begin
      miscompares++;
      $display("FAIL same_cycle_pixel_wins: got wr %b addr %h, expected 0 01", pal_wr, pal_addr);
    end
    push_pix(5'h01, 1'b0, 1'b0);
    step();
    pix_valid = 1'b0;
    #1;
    vectors++;
    if (pal_wr !== 1'b1 || pal_addr !== 5'h01 || pal_wdata !== 8'h11) begin
      miscompares++;
      $display("FAIL same_cycle_write: got wr %b addr %h data %h, expected 1 01 11", pal_wr, pal_addr, pal_wdata);
    end
    push_ack(1'b0, 1, 8'h00);
    shadow[1] = 8'h11;
    step();
    cpu_req = 1'b0; cpu_we = 1'b0;
    pix_valid = 1'b1; pix_idx = 5'h01;
    push_pix(5'h01, 1'b0, 1'b0);
    step();
    pix_valid = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_reset_mid_read();
    step();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'h03; pix_valid = 1'b0;
    step();
    pix_valid = 1'b1; pix_idx = 5'h03;
    rst = 1'b1;
    #1;
    vectors++;
    if ({color_valid, color, pix_drop, cpu_ack, cpu_rdata} !== 17'd0) begin
      miscompares++;
      $display("FAIL reset_mid_read: got valid %b color %h drop %b ack %b rdata %h, expected all 0",
               color_valid, color, pix_drop, cpu_ack, cpu_rdata);
    end
    cpu_req = 1'b0; pix_valid = 1'b0;
    last_color = 6'd0;
    step();
    step();
    rst = 1'b0;
    repeat (4) step();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 5'h02; cpu_wdata = 8'h33;
    #1;
    vectors++;
    if (pal_wr !== 1'b1 || pal_addr !== 5'h02) begin
      miscompares++;
      $display("FAIL post_reset_grant: got wr %b addr %h, expected 1 02", pal_wr, pal_addr);
    end
    push_ack(1'b0, 1, 8'h00);
    shadow[2] = 8'h33;
    step();
    cpu_req = 1'b0; cpu_we = 1'b0;
    repeat (3) step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write_read();
    test_pixel();
    test_backdrop();
    test_starve();
    test_same_cycle();
    test_reset_mid_read();
    repeat (3) step();
    vectors++;
    if (pix_q.size() != 0 || ack_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d colours and %0d acks outstanding, expected 0", pix_q.size(), ack_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ppu_pal_arbiter.md
Name: ppu_pal_arbiter

Overview:
- Owns the single port of the 32-entry PPU palette RAM, which has a 1-cycle registered read and mirrors $3F10/14/18/1C internally.
- Shares that port between two requesters:
  - the pixel pipeline, which does one colour lookup per dot;
  - the CPU $2007 path, which does byte reads and writes over a req/ack handshake.
- Applies the PPUMASK grayscale mask to pixel colours.
- Substitutes the backdrop index when rendering is disabled.

Parameters:
STARVE_LIMIT, 8, number of consecutive cycles a CPU request may be refused before it preempts the pixel pipeline (1..255)

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
render_en  in  1  PPUMASK rendering enabled (BG or sprites)
pix_valid  in  1  pixel lookup request this cycle
pix_idx  in  5  palette index from the pixel mux
bd_idx  in  5  backdrop index used when render_en=0
grayscale  in  1  PPUMASK bit 0
color_valid  out  1  colour output valid
color  out  6  NES colour index
pix_drop  out  1  1-cycle pulse aligned with color_valid when that lookup was preempted
cpu_req  in  1  CPU access request; level, held until ack
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  5  palette address (v[4:0])
cpu_wdata  in  8  write data
cpu_ack  out  1  1-cycle completion pulse
cpu_rdata  out  8  read data; valid with ack, held until next read ack
pal_addr  out  5  to palette RAM (combinational mux)
pal_wr  out  1  to palette RAM (combinational)
pal_wdata  out  8  to palette RAM
pal_rdata  in  8  from palette RAM; reflects pal_addr of the previous cycle

Behaviour:
- Reset (async, rst=1):
  - FSM goes to IDLE; wait_cnt=0.
  - color_valid, color, pix_drop, cpu_ack, cpu_rdata all 0.
  - Pipeline valid bits cleared; any in-flight CPU transaction is discarded and gets no ack.
- Pixel index: eff_idx = render_en ? pix_idx : bd_idx.
- Port grant, evaluated each cycle:
  - CPU granted iff FSM=IDLE, cpu_req=1, and either pix_valid=0 or wait_cnt>=STARVE_LIMIT.
  - If the CPU is granted: pal_addr=cpu_addr, pal_wr=cpu_we, pal_wdata=cpu_wdata.
  - Otherwise: pal_addr=eff_idx and pal_wr=0 (pal_addr is still driven when pix_valid=0).
  - pal_wr is never 1 except in a CPU-write grant cycle.
- wait_cnt:
  - Increments, saturating at 255, each cycle FSM=IDLE, cpu_req=1 and the CPU is not granted.
  - Clears on grant, and in any cycle with cpu_req=0.
- FSM (states IDLE, RD_CAP, ACK):
  - IDLE, write grant -> ACK.
  - IDLE, read grant -> RD_CAP.
  - RD_CAP: cpu_rdata <= pal_rdata -> ACK.
  - ACK: cpu_ack=1 for exactly this cycle -> IDLE.
  - In RD_CAP and ACK the RAM port is free for pixel lookups.
- Latency from the grant cycle G:
  - write: ack at G+1;
  - read: ack at G+2, with cpu_rdata valid at G+2.
- Requester rule: after ack, cpu_req must either be deasserted or carry a new request. A level still high in the IDLE cycle after ack is treated as a new request.
- Pixel pipeline, 2 cycles (request at N, output at N+2):
  - Stage 1 registers pix_valid, grayscale, and a dropped flag (CPU granted while pix_valid=1).
  - Stage 2 registers color_valid = stage-1 valid and pix_drop = valid & dropped.
  - Normal colour: color = pal_rdata[5:0] & (gray ? 6'h30 : 6'h3F).
  - On a dropped lookup: color holds its previous value.
  - When color_valid=0: color holds its value.
- Mirroring is done by the RAM. The arbiter passes 5-bit addresses unmodified.
- Simultaneous pix_valid and CPU write to the same address (below starve limit): pixel reads the old value; the write lands later.
- CPU write at G with a pixel read of the same address at G+1: pixel sees the new value.

Test Plan:
- Reset mid-read: assert rst in RD_CAP -> FSM IDLE, cpu_ack never pulses, cpu_rdata=0, color_valid=0.
- Idle port, CPU write addr 5'h03 data 8'h2A at cycle 0:
  - expected: pal_wr=1 at 0, ack at 1;
  - then a read of 5'h03 granted at 3 -> ack at 5 with cpu_rdata=8'h2A.
- Continuous pix_valid with render_en=1, idx 5'h03, RAM holds 8'h2A:
  - expected: color_valid from N+2, color=6'h2A;
  - with grayscale=1 at request -> color=6'h20.
- render_en=0, pix_idx=5'h07, bd_idx=5'h00, RAM[0]=8'h0F -> pal_addr=5'h00, color=6'h0F.
- CPU read pending under continuous pix_valid, STARVE_LIMIT=8:
  - expected: grant on the 9th cycle, i.e. refused 8 times;
  - pix_drop=1 two cycles after grant, with color equal to the previous colour;
  - ack 2 cycles after grant.
- Same-cycle CPU write 8'h11 to 5'h01 and pixel lookup of 5'h01 (old 8'h05) at cycle 0:
  - cycle 0: pixel wins, color=6'h05 at cycle 2;
  - cycle 1: pix_valid=0, so the write is granted;
  - next pixel lookup of 5'h01 returns 6'h11.
